// File: rtl/prg_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prg_mem_pkg : shared types and defaults for the PIO program-memory port     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package prg_mem_pkg;

  localparam int PRG_ADDR_W = 8;
  localparam int PRG_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_RDBACK   = 2'd2,
    ST_WAIT_LOW = 2'd3
  } prg_state_t;

endpackage
`default_nettype wire

// File: rtl/prg_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prg_sync_edge : multi-flop synchroniser with rising-edge pulse              |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module prg_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Reset to 1 so a strobe already high at reset release is not seen as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign level = r_sync[SYNC_STAGES-1];
  assign rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/prg_mem_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prg_mem_port : monitor PIO program-memory responder with CPU fetch port     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module prg_mem_port
  import prg_mem_pkg::*;
#(
  parameter int ADDR_W      = PRG_ADDR_W,
  parameter int DATA_W      = PRG_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              prg_clock,
  input  logic [ADDR_W-1:0] prg_ma,
  input  logic [DATA_W-1:0] prg_wd,
  input  logic              prg_we,
  output logic [DATA_W-1:0] prg_rd,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              prg_busy
);

  localparam logic [1:0] c_idle     = ST_IDLE;
  localparam logic [1:0] c_access   = ST_ACCESS;
  localparam logic [1:0] c_rdback   = ST_RDBACK;
  localparam logic [1:0] c_wait_low = ST_WAIT_LOW;

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_ma;
  logic [DATA_W-1:0] r_wd;
  logic              r_we;
  logic [DATA_W-1:0] r_prg_rd;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              w_level;
  logic              w_rise;

  prg_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk_clk),
    .rst_n    (reset_reset_n),
    .async_in (prg_clock),
    .level    (w_level),
    .rise     (w_rise)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state  <= c_idle;
      r_ma     <= '0;
      r_wd     <= '0;
      r_we     <= 1'b0;
      r_prg_rd <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_rise) begin
            r_ma    <= prg_ma;
            r_wd    <= prg_wd;
            r_we    <= prg_we;
            r_state <= c_access;
          end
        end
        c_access:   r_state <= c_rdback;
        c_rdback: begin
          // Write committed last cycle, so this returns the new value.
          r_prg_rd <= mem[r_ma];
          r_state  <= c_wait_low;
        end
        c_wait_low: if (!w_level) r_state <= c_idle;
        default:    r_state <= c_idle;
      endcase
    end
  end

  // Memory is never reset so it maps onto block RAM.
  always_ff @(posedge clk_clk) begin
    if (r_state == c_access && r_we) begin
      mem[r_ma] <= r_wd;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_cpu_rdata <= '0;
    end else begin
      r_cpu_rdata <= mem[cpu_addr];
    end
  end

  assign prg_rd    = r_prg_rd;
  assign cpu_rdata = r_cpu_rdata;
  assign prg_busy  = (r_state != c_idle);

endmodule
`default_nettype wire

// File: tb/tb_prg_mem_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_prg_mem_port : directed self-checking bench for prg_mem_port            |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_prg_mem_port;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n = 1'b0;
  logic       prg_clock = 1'b0;
  logic [7:0] prg_ma = '0;
  logic [7:0] prg_wd = '0;
  logic       prg_we = 1'b0;
  logic [7:0] prg_rd;
  logic [7:0] cpu_addr = '0;
  logic [7:0] cpu_rdata;
  logic       prg_busy;

  int n_cmp = 0;
  int n_err = 0;
  int busy_rises = 0;
  logic busy_d = 1'b0;
  int rises_before;
  logic found;

  prg_mem_port u_dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .prg_clock     (prg_clock),
    .prg_ma        (prg_ma),
    .prg_wd        (prg_wd),
    .prg_we        (prg_we),
    .prg_rd        (prg_rd),
    .cpu_addr      (cpu_addr),
    .cpu_rdata     (cpu_rdata),
    .prg_busy      (prg_busy)
  );

  always #5 clk_clk = ~clk_clk;

  // Counts accesses started, independent of the data path.
  always @(posedge clk_clk) begin
    busy_d <= prg_busy;
    if (prg_busy && !busy_d) busy_rises <= busy_rises + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] a, input logic [7:0] d, input logic w,
                       input int hi, input int lo);
    prg_ma = a; prg_wd = d; prg_we = w;
    @(negedge clk_clk);
    prg_clock = 1'b1;
    repeat (hi) @(negedge clk_clk);
    prg_clock = 1'b0;
    repeat (lo) @(negedge clk_clk);
  endtask

  task automatic cpu_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
    @(negedge clk_clk);
    cpu_addr = a;
    @(posedge clk_clk);
    #1 chk(tag, {24'd0, cpu_rdata}, {24'd0, exp});
  endtask

  task automatic wait_busy(input string tag);
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_clk);
      if (prg_busy) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) chk(tag, 32'd0, 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk_clk);
    chk("rst_prg_rd", {24'd0, prg_rd}, 32'h0);
    chk("rst_cpu_rdata", {24'd0, cpu_rdata}, 32'h0);
    chk("rst_busy", {31'd0, prg_busy}, 32'h0);
    reset_reset_n = 1'b1;
    repeat (2) @(negedge clk_clk);

    // Write then read back within 6 cycles of the strobe edge
    prg_ma = 8'h10; prg_wd = 8'hA5; prg_we = 1'b1;
    @(negedge clk_clk);
    prg_clock = 1'b1;
    repeat (6) @(posedge clk_clk);
    #1 chk("wr_prg_rd", {24'd0, prg_rd}, 32'hA5);
    chk("wr_busy_high", {31'd0, prg_busy}, 32'h1);
    repeat (4) @(negedge clk_clk);
    prg_clock = 1'b0;
    repeat (8) @(negedge clk_clk);
    cpu_read("wr_cpu", 8'h10, 8'hA5);

    // Read-only access must not disturb memory
    pulse(8'hFF, 8'h3C, 1'b1, 8, 8);
    pulse(8'hFF, 8'h99, 1'b0, 8, 8);
    chk("rd_prg_rd", {24'd0, prg_rd}, 32'h3C);
    cpu_read("rd_cpu_unchanged", 8'hFF, 8'h3C);

    // Long 50-cycle pulse: one access only, busy clears 3 cycles after fall
    rises_before = busy_rises;
    prg_ma = 8'h30; prg_wd = 8'h01; prg_we = 1'b1;
    @(negedge clk_clk);
    prg_clock = 1'b1;
    repeat (50) @(negedge clk_clk);
    chk("long_busy_held", {31'd0, prg_busy}, 32'h1);
    prg_clock = 1'b0;
    repeat (2) @(posedge clk_clk);
    #1 chk("long_busy_after2", {31'd0, prg_busy}, 32'h1);
    @(posedge clk_clk);
    #1 chk("long_busy_after3", {31'd0, prg_busy}, 32'h0);
    repeat (8) @(negedge clk_clk);
    chk("long_one_access", busy_rises - rises_before, 32'd1);
    cpu_read("long_cpu", 8'h30, 8'h01);

    // Collision: CPU reads old data in ACCESS+1, new data the cycle after
    pulse(8'h20, 8'h11, 1'b1, 8, 8);
    cpu_addr = 8'h20;
    prg_ma = 8'h20; prg_wd = 8'h22; prg_we = 1'b1;
    @(negedge clk_clk);
    prg_clock = 1'b1;
    wait_busy("coll_timeout");
    @(negedge clk_clk);
    chk("coll_old", {24'd0, cpu_rdata}, 32'h11);
    @(negedge clk_clk);
    chk("coll_new", {24'd0, cpu_rdata}, 32'h22);
    repeat (6) @(negedge clk_clk);
    prg_clock = 1'b0;
    repeat (8) @(negedge clk_clk);

    // Reset during ACCESS with strobe held high: write dropped, no restart
    pulse(8'h05, 8'h5A, 1'b1, 8, 8);
    chk("rstmid_pre_rd", {24'd0, prg_rd}, 32'h5A);
    prg_ma = 8'h05; prg_wd = 8'h77; prg_we = 1'b1;
    @(negedge clk_clk);
    prg_clock = 1'b1;
    wait_busy("rstmid_timeout");
    reset_reset_n = 1'b0;
    #1 chk("rstmid_prg_rd", {24'd0, prg_rd}, 32'h0);
    chk("rstmid_busy", {31'd0, prg_busy}, 32'h0);
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    rises_before = busy_rises;
    repeat (10) @(negedge clk_clk);
    chk("rstmid_no_restart", busy_rises - rises_before, 32'd0);
    chk("rstmid_busy_after", {31'd0, prg_busy}, 32'h0);
    cpu_read("rstmid_write_dropped", 8'h05, 8'h5A);
    prg_clock = 1'b0;
    repeat (8) @(negedge clk_clk);
    pulse(8'h05, 8'h00, 1'b0, 8, 8);
    chk("rstmid_fresh_edge", {24'd0, prg_rd}, 32'h5A);

    // Back-to-back accesses at minimum level spacing
    for (int i = 0; i < 4; i++) begin
      pulse(i[7:0], 8'h80 + i[7:0], 1'b1, 8, 8);
    end
    for (int i = 0; i < 4; i++) begin
      cpu_read($sformatf("b2b_cpu_%0d", i), i[7:0], 8'h80 + i[7:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
